// File: rtl/io_pkg.sv
// Shared I/O definitions: bus width, switch conditioner defaults, counter sizing.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package io_pkg;

  localparam int IO_WIDTH       = 32;
  localparam int SW_TICK_DIV    = 50000;
  localparam int SW_STABLE_N    = 4;
  localparam int SW_SYNC_STAGES = 2;

  // Ceiling log2; clog2(1) == 0. Loop stops at 30 so 1<<i never goes negative.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Width of a counter that must hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/switch_conditioner_if.sv
// Switch conditioner signal bundle: raw pins and clear strobe in, conditioned word out.
// Latency: n/a (wires only).
// Backpressure: none; every signal is a level or a single-cycle strobe.
// master: the side driving pins/clear (board + I/O write path); slave: the conditioner.
interface switch_conditioner_if
  import io_pkg::*;
#(
  parameter int WIDTH = IO_WIDTH
) ();

  logic [WIDTH-1:0] switch_raw;
  logic             clr_sticky;
  logic [WIDTH-1:0] switch_clean;
  logic [WIDTH-1:0] switch_changed;
  logic             change_any;
  logic [WIDTH-1:0] sticky_mask;
  logic             sample_tick;

  modport master (
    output switch_raw, clr_sticky,
    input  switch_clean, switch_changed, change_any, sticky_mask, sample_tick
  );

  modport slave (
    input  switch_raw, clr_sticky,
    output switch_clean, switch_changed, change_any, sticky_mask, sample_tick
  );

endinterface

// File: rtl/switch_conditioner_debounce_bit.sv
// One switch bit: synchroniser chain, debounce counter, clean flop and change-pulse flop.
// Latency: SYNC_STAGES cycles plus up to STABLE_N sample ticks from raw edge to clean flip.
// Backpressure: none; the bit state only advances on cycles where sample_tick is high.
// Ports: clk, reset_n; sample_tick (shared strobe); raw (async pin);
//        clean (debounced level); changed (registered pulse); changed_nxt (next value of changed).
module debounce_bit
  import io_pkg::*;
#(
  parameter int STABLE_N    = SW_STABLE_N,
  parameter int SYNC_STAGES = SW_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sample_tick,
  input  logic raw,
  output logic clean,
  output logic changed,
  output logic changed_nxt
);

  localparam int CW = cnt_width(STABLE_N);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   clean_q, clean_d;
  logic                   changed_q, changed_d;
  logic                   sync_bit;

  assign sync_bit = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], raw};
    cnt_d     = cnt_q;
    clean_d   = clean_q;
    changed_d = 1'b0;
    if (sample_tick) begin
      if (sync_bit == clean_q) begin
        // Any sample agreeing with the clean level discards the run so far.
        cnt_d = '0;
      end else if (cnt_q == CW'(STABLE_N - 1)) begin
        clean_d   = ~clean_q;
        cnt_d     = '0;
        changed_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q    <= '0;
      cnt_q     <= '0;
      clean_q   <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      cnt_q     <= cnt_d;
      clean_q   <= clean_d;
      changed_q <= changed_d;
    end
  end

  assign clean       = clean_q;
  assign changed     = changed_q;
  assign changed_nxt = changed_d;

endmodule

// File: rtl/switch_conditioner.sv
// Board switch conditioner: per-bit sync + debounce, change pulses and a CPU-clearable sticky mask.
// Latency: SYNC_STAGES cycles plus up to STABLE_N tick periods from raw edge to switch_clean.
// Backpressure: none; outputs are levels/strobes, clr_sticky is honoured every cycle.
// Ports: clk, reset_n (async active-low); bus.slave carries switch_raw/clr_sticky in and
//        switch_clean, switch_changed, change_any, sticky_mask, sample_tick out.
module switch_conditioner
  import io_pkg::*;
#(
  parameter int WIDTH       = IO_WIDTH,
  parameter int TICK_DIV    = SW_TICK_DIV,
  parameter int STABLE_N    = SW_STABLE_N,
  parameter int SYNC_STAGES = SW_SYNC_STAGES
) (
  input  logic                 clk,
  input  logic                 reset_n,
  switch_conditioner_if.slave  bus
);

  localparam int TCW = cnt_width(TICK_DIV);

  logic [TCW-1:0]   tick_cnt_q, tick_cnt_d;
  logic             sample_tick_q, sample_tick_d;
  logic [WIDTH-1:0] sticky_q, sticky_d;
  logic [WIDTH-1:0] clean_w;
  logic [WIDTH-1:0] changed_w;
  logic [WIDTH-1:0] changed_nxt_w;
  logic             tick_hit;

  // Free-running divider; the strobe is registered so it is glitch-free for the LED/debug pin.
  always_comb begin
    tick_hit      = (tick_cnt_q == TCW'(TICK_DIV - 1));
    tick_cnt_d    = tick_hit ? '0 : tick_cnt_q + 1'b1;
    sample_tick_d = tick_hit;
  end

  // Set wins over clear: a bit flipping in the clear cycle must not be lost.
  always_comb begin
    sticky_d = (bus.clr_sticky ? '0 : sticky_q) | changed_nxt_w;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt_q    <= '0;
      sample_tick_q <= 1'b0;
      sticky_q      <= '0;
    end else begin
      tick_cnt_q    <= tick_cnt_d;
      sample_tick_q <= sample_tick_d;
      sticky_q      <= sticky_d;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .STABLE_N    (STABLE_N),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_bit (
      .clk         (clk),
      .reset_n     (reset_n),
      .sample_tick (sample_tick_q),
      .raw         (bus.switch_raw[i]),
      .clean       (clean_w[i]),
      .changed     (changed_w[i]),
      .changed_nxt (changed_nxt_w[i])
    );
  end

  assign bus.switch_clean   = clean_w;
  assign bus.switch_changed = changed_w;
  assign bus.change_any     = |changed_w;
  assign bus.sticky_mask    = sticky_q;
  assign bus.sample_tick    = sample_tick_q;

endmodule

// File: tb/tb_switch_conditioner.sv
// Bench for switch_conditioner: two instances (TICK_DIV=4 and TICK_DIV=1, STABLE_N=3, SYNC_STAGES=2)
// share stimulus; a cycle-level reference model derived from tick period and pin history is compared
// every cycle, plus a vector table and directed multi-cycle sequences with hand-derived constants.
module tb_switch_conditioner;

  localparam int SN = 3;
  localparam int TD [2] = '{4, 1};

  logic clk;
  logic reset_n;

  switch_conditioner_if if4 ();
  switch_conditioner_if if1 ();

  switch_conditioner #(.WIDTH(32), .TICK_DIV(4), .STABLE_N(SN), .SYNC_STAGES(2)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .bus(if4));
  switch_conditioner #(.WIDTH(32), .TICK_DIV(1), .STABLE_N(SN), .SYNC_STAGES(2)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .bus(if1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests;
  int fails;

  // ---------------- reference model ----------------
  int          n;                 // edges since reset release
  logic [31:0] hist[$];           // hist[k] = pins sampled at edge k+1
  logic [31:0] m_clean  [2];
  logic [31:0] m_chg    [2];
  logic [31:0] m_sticky [2];
  logic        m_tick   [2];
  int          m_cnt    [2][32];

  task automatic model_reset();
    n = 0;
    hist.delete();
    for (int k = 0; k < 2; k++) begin
      m_clean[k] = '0; m_chg[k] = '0; m_sticky[k] = '0; m_tick[k] = 1'b0;
      for (int b = 0; b < 32; b++) m_cnt[k][b] = 0;
    end
  endtask

  // Pins seen by the debouncer at edge e are the pins sampled two edges earlier.
  function automatic logic [31:0] synced_at(input int e);
    return (e >= 3) ? hist[e-3] : 32'h0;
  endfunction

  task automatic model_edge(input logic [31:0] raw, input logic clr);
    logic [31:0] s;
    n++;
    hist.push_back(raw);
    s = synced_at(n);
    for (int k = 0; k < 2; k++) begin
      m_chg[k] = '0;
      if (m_tick[k]) begin
        for (int b = 0; b < 32; b++) begin
          if (s[b] == m_clean[k][b]) m_cnt[k][b] = 0;
          else if (m_cnt[k][b] + 1 == SN) begin
            m_clean[k][b] = ~m_clean[k][b];
            m_chg[k][b]   = 1'b1;
            m_cnt[k][b]   = 0;
          end else m_cnt[k][b]++;
        end
      end
      m_sticky[k] = (clr ? 32'h0 : m_sticky[k]) | m_chg[k];
      m_tick[k]   = ((n % TD[k]) == 0);
    end
  endtask

  function automatic logic will_flip(input int k, input int b);
    logic [31:0] s;
    s = synced_at(n + 1);
    return m_tick[k] && (s[b] != m_clean[k][b]) && (m_cnt[k][b] == SN - 1);
  endfunction

  // ---------------- checking ----------------
  task automatic cmp32(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmp_inst(input int k, input logic [31:0] c, input logic [31:0] ch,
                          input logic [31:0] st, input logic any, input logic tk);
    tests++;
    if (c !== m_clean[k] || ch !== m_chg[k] || st !== m_sticky[k] ||
        any !== (|m_chg[k]) || tk !== m_tick[k]) begin
      fails++;
      $display("FAIL model td=%0d n=%0d: clean %08h/%08h chg %08h/%08h sticky %08h/%08h any %b/%b tick %b/%b",
               TD[k], n, c, m_clean[k], ch, m_chg[k], st, m_sticky[k], any, |m_chg[k], tk, m_tick[k]);
    end
  endtask

  task automatic check_model();
    cmp_inst(0, if4.switch_clean, if4.switch_changed, if4.sticky_mask, if4.change_any, if4.sample_tick);
    cmp_inst(1, if1.switch_clean, if1.switch_changed, if1.sticky_mask, if1.change_any, if1.sample_tick);
  endtask

  task automatic check_zero(input string name);
    cmp32({name, " td4"}, if4.switch_clean | if4.switch_changed | if4.sticky_mask |
          {30'h0, if4.change_any, if4.sample_tick}, 32'h0);
    cmp32({name, " td1"}, if1.switch_clean | if1.switch_changed | if1.sticky_mask |
          {30'h0, if1.change_any, if1.sample_tick}, 32'h0);
  endtask

  // Called at posedge+1; drives, takes one edge, then compares with the model.
  task automatic step(input logic [31:0] raw, input logic clr);
    if4.switch_raw = raw; if1.switch_raw = raw;
    if4.clr_sticky = clr; if1.clr_sticky = clr;
    @(posedge clk);
    model_edge(raw, clr);
    #1;
    check_model();
  endtask

  // Reset lands mid-cycle (posedge+4) and must clear outputs without waiting for an edge.
  task automatic do_reset(input logic [31:0] raw, input string name);
    if4.switch_raw = raw; if1.switch_raw = raw;
    if4.clr_sticky = 1'b0; if1.clr_sticky = 1'b0;
    #3;
    reset_n = 1'b0;
    #1;
    check_zero({name, " async"});
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_zero({name, " held"});
    end
    reset_n = 1'b1;
    model_reset();
  endtask

  // With pins held since reset: TD=4 flips on edge 13 (ticks sampled at 5, 9, 13),
  // TD=1 flips on edge 5 (samples at 3, 4, 5).
  task automatic post_reset_flip(input logic [31:0] raw, input string name);
    for (int e = 1; e <= 14; e++) begin
      step(raw, 1'b0);
      if (e == 4)  cmp32({name, " td1 pre"},  if1.switch_clean, 32'h0);
      if (e == 5)  cmp32({name, " td1 flip"}, if1.switch_clean, raw);
      if (e == 5)  cmp32({name, " td1 pulse"}, if1.switch_changed, raw);
      if (e == 12) cmp32({name, " td4 pre"},  if4.switch_clean, 32'h0);
      if (e == 13) cmp32({name, " td4 flip"}, if4.switch_clean, raw);
      if (e == 13) cmp32({name, " td4 pulse"}, if4.switch_changed, raw);
      if (e == 13) cmp32({name, " td4 any"},  {31'h0, if4.change_any}, 32'h1);
      if (e == 14) cmp32({name, " td4 pulse end"}, if4.switch_changed, 32'h0);
    end
  endtask

  typedef struct {
    logic [31:0] raw;
    logic        clr;
    int          cycles;
    logic [31:0] exp_clean;
    logic [31:0] exp_sticky;
  } vec_t;

  vec_t vecs [6];

  initial begin
    logic [31:0] r;
    logic        c;
    int          guard;
    tests = 0;
    fails = 0;
    reset_n = 1'b0;
    if4.switch_raw = '0; if1.switch_raw = '0;
    if4.clr_sticky = 1'b0; if1.clr_sticky = 1'b0;
    model_reset();

    // Expectations for TD=4 counted in edges after a reset with pins at 0.
    vecs[0] = '{32'h0000_00A5, 1'b0, 20, 32'h0000_00A5, 32'h0000_00A5};
    vecs[1] = '{32'h0000_00A5, 1'b1,  1, 32'h0000_00A5, 32'h0000_0000};
    vecs[2] = '{32'h0000_00A4, 1'b0,  4, 32'h0000_00A5, 32'h0000_0000};
    vecs[3] = '{32'h0000_00A5, 1'b0,  8, 32'h0000_00A5, 32'h0000_0000};
    vecs[4] = '{32'h0000_005A, 1'b0, 16, 32'h0000_005A, 32'h0000_00FF};
    vecs[5] = '{32'h0000_005A, 1'b1,  1, 32'h0000_005A, 32'h0000_0000};

    // 1: all switches high through reset
    do_reset(32'hFFFF_FFFF, "rst_ones");
    post_reset_flip(32'hFFFF_FFFF, "ones");
    cmp32("ones sticky", if4.sticky_mask, 32'hFFFF_FFFF);

    // 2: vector table
    do_reset(32'h0, "rst_tab");
    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < vecs[v].cycles; i++) step(vecs[v].raw, vecs[v].clr);
      cmp32($sformatf("vec%0d clean", v),  if4.switch_clean, vecs[v].exp_clean);
      cmp32($sformatf("vec%0d sticky", v), if4.sticky_mask,  vecs[v].exp_sticky);
    end

    // 6: reset after two differing samples on bit4; count must start over
    guard = 0;
    while (m_cnt[0][4] != 2 && guard < 20) begin
      step(32'h0000_004A, 1'b0);
      guard++;
    end
    cmp32("bit4 cnt reached", {31'h0, (guard < 20)}, 32'h1);
    do_reset(32'h0000_004A, "rst_mid");
    post_reset_flip(32'h0000_004A, "mid");

    // 5: clear strobe coinciding with bit3 flip
    do_reset(32'h0, "rst_clr");
    for (int i = 0; i < 20; i++) step(32'h1, 1'b0);
    cmp32("sticky pre", if4.sticky_mask, 32'h1);
    guard = 0;
    while (!will_flip(0, 3) && guard < 40) begin
      step(32'h9, 1'b0);
      guard++;
    end
    cmp32("bit3 flip found", {31'h0, (guard < 40)}, 32'h1);
    step(32'h9, 1'b1);
    cmp32("clr vs set sticky", if4.sticky_mask, 32'h8);
    cmp32("clr vs set clean", if4.switch_clean, 32'h9);

    // 4: bit7 short low run rejected, long low run accepted
    for (int i = 0; i < 20; i++) step(32'h89, 1'b0);
    cmp32("bit7 high", if4.switch_clean, 32'h89);
    for (int i = 0; i < 8; i++)  step(32'h09, 1'b0);
    for (int i = 0; i < 12; i++) step(32'h89, 1'b0);
    cmp32("bit7 glitch rejected", if4.switch_clean, 32'h89);
    for (int i = 0; i < 16; i++) step(32'h09, 1'b0);
    cmp32("bit7 long low", if4.switch_clean, 32'h09);

    // 3: bit0 alternating every tick never reaches the clean word
    step(32'h09, 1'b1);
    for (int t = 0; t < 10; t++)
      for (int i = 0; i < 4; i++) step((t % 2 == 0) ? 32'h08 : 32'h09, 1'b0);
    for (int i = 0; i < 16; i++) step(32'h09, 1'b0);
    cmp32("bounce clean", if4.switch_clean, 32'h09);
    cmp32("bounce sticky", if4.sticky_mask, 32'h0);

    // Random pin activity with bounces and clear strobes
    r = 32'h09;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) r = r ^ ($urandom() & $urandom());
      c = ($urandom_range(0, 19) == 0);
      step(r, c);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/switch_conditioner.md
Name: switch_conditioner

Overview:
- Conditions the 32 board slide-switches before they reach PORT_A of the I/O buffer.
- Per-bit processing: multi-flop synchronisation, then counter-based debounce on a shared sample tick.
- Outputs: a clean switch word, per-bit one-cycle change pulses, and a sticky change mask the CPU can poll and clear.
- Sits between the top-level switch pins and the I/O buffer port input, in the CPU clock domain (PLL output).

Parameters:
- WIDTH, 32: number of switch bits.
- TICK_DIV, 50000: clk cycles per debounce sample tick; legal range >= 1.
- STABLE_N, 4: consecutive differing samples required to flip a clean bit; legal range >= 1.
- SYNC_STAGES, 2: synchroniser depth; legal range >= 2.

Ports:
- clk  in  1  system clock (PLL output).
- reset_n  in  1  asynchronous active-low reset.
- switch_raw  in  WIDTH  asynchronous switch pins.
- clr_sticky  in  1  clears sticky_mask (one-cycle strobe from the I/O write path).
- switch_clean  out  WIDTH  debounced switch value, feeds PORT_A.
- switch_changed  out  WIDTH  per-bit one-cycle pulse when the clean bit flips.
- change_any  out  1  OR of switch_changed, same cycle.
- sticky_mask  out  WIDTH  accumulated changed bits since the last clear.
- sample_tick  out  1  debounce sample strobe (debug/LED).

Behaviour:
- Reset (reset_n low, asynchronous, takes effect immediately):
  - All sync flops, the tick counter, per-bit counters, switch_clean, switch_changed, change_any, sticky_mask and sample_tick go to 0.
  - Switches held high through reset appear on switch_clean after the normal debounce delay.
- Synchroniser:
  - SYNC_STAGES flop chain per bit; sync[i] is the last stage.
  - A raw change is visible on sync SYNC_STAGES rising edges later.
- Tick counter:
  - Counts 0..TICK_DIV-1 and wraps to 0.
  - sample_tick is registered and high for exactly one cycle when the count equals TICK_DIV-1.
  - TICK_DIV=1 gives sample_tick high every cycle after reset.
- Per-bit debounce (on cycles with sample_tick=1 only; otherwise hold):
  - If sync[i]==switch_clean[i]: cnt[i] <= 0.
  - Else if cnt[i]==STABLE_N-1: switch_clean[i] toggles, cnt[i] <= 0, switch_changed[i] <= 1.
  - Else: cnt[i] <= cnt[i]+1.
  - STABLE_N=1 flips on the first differing sample.
  - cnt width is clog2(STABLE_N), minimum 1; cnt never exceeds STABLE_N-1.
- switch_changed:
  - Registered, high for exactly one cycle, the same cycle switch_clean shows the new value.
  - 0 on all other cycles.
  - change_any is the combinational OR of the registered switch_changed.
- sticky_mask:
  - Each cycle: next = (clr_sticky ? 0 : sticky_mask) | switch_changed_next.
  - A change occurring in the clr_sticky cycle survives, so set wins per bit.
- Latency:
  - Raw edge to clean update is SYNC_STAGES cycles plus up to STABLE_N full tick periods.
  - The minimum is reached when the first differing sample lands on the next tick.
- Glitch rejection:
  - Any sample equal to the clean value restarts the count.
  - Bounces shorter than STABLE_N consecutive samples never reach switch_clean.
- Bits are fully independent; any subset may flip on the same tick.

Decomposition:
- Shared package io_pkg:
  - IO_WIDTH=32.
  - Default SW_TICK_DIV and SW_STABLE_N.
  - Helper clog2 function used for counter widths.
- One sub-module, debounce_bit:
  - Contains the sync chain, cnt, clean flop and changed flop for a single bit.
  - Instantiated WIDTH times via generate.
- The top module holds the shared tick counter and the sticky register.

Test Plan (TICK_DIV=4, STABLE_N=3, SYNC_STAGES=2 unless stated):
1. Hold switch_raw=0xFFFFFFFF during reset -> every output reads 0 throughout reset; after release switch_clean=0xFFFFFFFF exactly on the 3rd sample_tick after the sync delay, with switch_changed=0xFFFFFFFF for 1 cycle.
2. From clean 0, step raw to 0x000000A5 and hold -> switch_clean=0x000000A5 on the 3rd qualifying tick; switch_changed=0x000000A5 and change_any=1 for exactly one cycle; sticky_mask=0x000000A5 afterwards.
3. Bit0 toggles every tick for 10 ticks, then returns to the clean value -> switch_clean[0] never changes; switch_changed and sticky_mask stay 0.
4. Clean bit7=1; raw bit7 low for 2 samples, then high -> no flip, cnt resets; a later 3-sample low produces the flip.
5. sticky_mask=0x00000001; assert clr_sticky in the same cycle bit3 flips -> sticky_mask=0x00000008 the next cycle.
6. After 2 differing samples on bit4, pulse reset_n low mid-cycle -> outputs 0 asynchronously; after release with raw held, 3 fresh ticks are needed before the flip (TICK_DIV=1 variant: flip 3 cycles after sync delay).
